vga_pattern_sequencer: RTL



---
 rtl/vga_pattern_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_pattern_sequencer.sv
// Selects the VGA test pattern from UART command bytes; changes are applied only at
// the start of vertical sync. Optional command echo to UART TX under `VGA_SEQ_ECHO_EN`.
module vga_pattern_sequencer #(
  parameter int unsigned NUM_PATTERNS  = 8,
  parameter int unsigned RESET_PATTERN = 4,
  parameter int unsigned AUTO_FRAMES   = 120
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  input  logic       i_VSync,
  output logic [3:0] o_Pattern,
  output logic       o_Pattern_Changed,
  output logic       o_Auto,
  output logic       o_Pending
`ifdef VGA_SEQ_ECHO_EN
  ,
  input  logic       i_Tx_Active,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte
`endif
);

  localparam int unsigned PAT_W  = 4;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned BYTE_W = 8;

  localparam logic [PAT_W-1:0]  LAST_PAT  = PAT_W'(NUM_PATTERNS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(AUTO_FRAMES - 1);
  localparam logic [BYTE_W-1:0] CH_PLUS   = 8'h2B;
  localparam logic [BYTE_W-1:0] CH_MINUS  = 8'h2D;
  localparam logic [BYTE_W-1:0] CH_AUTO   = 8'h61;
  localparam logic [BYTE_W-1:0] CH_STOP   = 8'h73;

  function automatic logic [PAT_W-1:0] pat_inc(input logic [PAT_W-1:0] p);
    return (p == LAST_PAT) ? PAT_W'(0) : p + PAT_W'(1);
  endfunction

  function automatic logic [PAT_W-1:0] pat_dec(input logic [PAT_W-1:0] p);
    return (p == PAT_W'(0)) ? LAST_PAT : p - PAT_W'(1);
  endfunction

  logic             r_vsync_prev;
  logic [PAT_W-1:0] r_target;
  logic [CNT_W-1:0] r_frame_cnt;

  logic [PAT_W-1:0] pattern_nxt;
  logic [PAT_W-1:0] target_nxt;
  logic [PAT_W-1:0] base;
  logic [CNT_W-1:0] cnt_nxt;
  logic             changed_nxt;
  logic             auto_nxt;
  logic             pending_nxt;

  logic boundary;
  logic is_digit;
  logic is_plus;
  logic is_minus;
  logic is_auto;
  logic is_stop;

  // Frame boundary is the falling edge of the active-low VSync pulse.
  assign boundary = r_vsync_prev & ~i_VSync;

  // Digits map 0x30+n to pattern n; the low nibble is n itself.
  assign is_digit = (i_Rx_Byte[7:4] == 4'h3) &&
                    ({1'b0, i_Rx_Byte[3:0]} < 5'(NUM_PATTERNS));
  assign is_plus  = (i_Rx_Byte == CH_PLUS);
  assign is_minus = (i_Rx_Byte == CH_MINUS);
  assign is_auto  = (i_Rx_Byte == CH_AUTO);
  assign is_stop  = (i_Rx_Byte == CH_STOP);

  assign base = o_Pending ? r_target : o_Pattern;

  // Boundary acts on pre-command state; a command in the same cycle overrides afterwards.
  always_comb begin
    pattern_nxt = o_Pattern;
    target_nxt  = r_target;
    cnt_nxt     = r_frame_cnt;
    changed_nxt = 1'b0;
    auto_nxt    = o_Auto;
    pending_nxt = o_Pending;

    if (boundary) begin
      if (o_Pending) begin
        pattern_nxt = r_target;
        pending_nxt = 1'b0;
        cnt_nxt     = CNT_W'(0);
        changed_nxt = 1'b1;
      end else if (o_Auto) begin
        if (r_frame_cnt == LAST_CNT) begin
          pattern_nxt = pat_inc(o_Pattern);
          cnt_nxt     = CNT_W'(0);
          changed_nxt = 1'b1;
        end else begin
          cnt_nxt = r_frame_cnt + CNT_W'(1);
        end
      end
    end

    if (i_Rx_DV) begin
      if (is_digit) begin
        target_nxt  = i_Rx_Byte[PAT_W-1:0];
        pending_nxt = 1'b1;
        auto_nxt    = 1'b0;
      end else if (is_plus) begin
        target_nxt  = pat_inc(base);
        pending_nxt = 1'b1;
      end else if (is_minus) begin
        target_nxt  = pat_dec(base);
        pending_nxt = 1'b1;
      end else if (is_auto) begin
        auto_nxt = 1'b1;
        cnt_nxt  = CNT_W'(0);
      end else if (is_stop) begin
        auto_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_vsync_prev      <= 1'b1;
      o_Pattern         <= PAT_W'(RESET_PATTERN);
      r_target          <= PAT_W'(RESET_PATTERN);
      r_frame_cnt       <= CNT_W'(0);
      o_Pattern_Changed <= 1'b0;
      o_Auto            <= 1'b0;
      o_Pending         <= 1'b0;
    end else begin
      r_vsync_prev      <= i_VSync;
      o_Pattern         <= pattern_nxt;
      r_target          <= target_nxt;
      r_frame_cnt       <= cnt_nxt;
      o_Pattern_Changed <= changed_nxt;
      o_Auto            <= auto_nxt;
      o_Pending         <= pending_nxt;
    end
  end

`ifdef VGA_SEQ_ECHO_EN
  typedef enum logic [1:0] {
    ECHO_IDLE,
    ECHO_LOAD,
    ECHO_SEND,
    ECHO_WAIT
  } echo_state_t;

  localparam logic [BYTE_W-1:0] CH_QUERY = 8'h3F;

  echo_state_t       r_echo_state;
  echo_state_t       echo_state_nxt;
  logic              r_seen_busy;
  logic              seen_busy_nxt;
  logic              r_wait_cnt;
  logic              wait_cnt_nxt;
  logic              tx_dv_nxt;
  logic [BYTE_W-1:0] tx_byte_nxt;
  logic              cmd_valid;

  assign cmd_valid = is_digit | is_plus | is_minus | is_auto | is_stop;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_echo_state <= ECHO_IDLE;
      r_seen_busy  <= 1'b0;
      r_wait_cnt   <= 1'b0;
      o_Tx_DV      <= 1'b0;
      o_Tx_Byte    <= BYTE_W'(0);
    end else begin
      r_echo_state <= echo_state_nxt;
      r_seen_busy  <= seen_busy_nxt;
      r_wait_cnt   <= wait_cnt_nxt;
      o_Tx_DV      <= tx_dv_nxt;
      o_Tx_Byte    <= tx_byte_nxt;
    end
  end

  // WAIT exits on TX busy falling, or after two idle cycles if TX never went busy.
  always_comb begin
    echo_state_nxt = r_echo_state;
    seen_busy_nxt  = r_seen_busy;
    wait_cnt_nxt   = r_wait_cnt;
    tx_dv_nxt      = 1'b0;
    tx_byte_nxt    = o_Tx_Byte;

    unique case (r_echo_state)
      ECHO_IDLE: begin
        if (i_Rx_DV) begin
          echo_state_nxt = ECHO_LOAD;
          tx_byte_nxt    = cmd_valid ? i_Rx_Byte : CH_QUERY;
        end
      end
      ECHO_LOAD: begin
        if (!i_Tx_Active) begin
          echo_state_nxt = ECHO_SEND;
          tx_dv_nxt      = 1'b1;
        end
      end
      ECHO_SEND: begin
        echo_state_nxt = ECHO_WAIT;
        seen_busy_nxt  = i_Tx_Active;
        wait_cnt_nxt   = 1'b0;
      end
      ECHO_WAIT: begin
        if (i_Tx_Active) begin
          seen_busy_nxt = 1'b1;
        end else if (r_seen_busy || r_wait_cnt) begin
          echo_state_nxt = ECHO_IDLE;
        end else begin
          wait_cnt_nxt = 1'b1;
        end
      end
      default: echo_state_nxt = ECHO_IDLE;
    endcase
  end
`endif

endmodule
